// File: rtl/detect_event_monitor_if.sv
// Snapshot handshake between the event monitor (master) and its consumer (slave).
interface detect_event_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             snap_valid;
  logic             snap_ready;
  logic [CNT_W-1:0] snap_count;
  logic             snap_sat;

  modport master (
    output snap_valid,
    output snap_count,
    output snap_sat,
    input  snap_ready
  );

  modport slave (
    input  snap_valid,
    input  snap_count,
    input  snap_sat,
    output snap_ready
  );
endinterface

// File: rtl/detect_event_monitor.sv
// Windowed match counter behind the sequence detector, with snapshot port, threshold irq and overrun flag.
// Optional DET_MON_EDGE_EN: count only 0->1 transitions of det_in instead of every high cycle.
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | monitor off; live count and window counter held at 0
// S_RUN  | counting matches over windows of WINDOW cycles
module detect_event_monitor #(
  parameter int          CNT_W  = 8,
  parameter int          WIN_W  = 16,
  parameter int unsigned WINDOW = 1000
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   det_in,
  input  logic                   en,
  input  logic [CNT_W-1:0]       thresh,
  input  logic                   clr_ovr,
  output logic                   snap_ovr,
  output logic                   irq,
  output logic                   busy,
  detect_event_monitor_if.master snap
);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] live_cnt_q, cnt_nxt;
  logic             sat_q, sat_nxt;
  logic [WIN_W-1:0] win_cnt_q;
  logic             armed_q;
  logic             irq_q;
  logic             snap_valid_q;
  logic [CNT_W-1:0] snap_count_q;
  logic             snap_sat_q;
  logic             ovr_q;

  logic active, evt, win_end, load, irq_fire;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en)  state_d = S_RUN;
      S_RUN:   if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A RUN cycle with en low is the exit cycle: its partial window is thrown away.
  assign active = (state_q == S_RUN) && en;

`ifdef DET_MON_EDGE_EN
  logic det_prev_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) det_prev_q <= 1'b0;
    else        det_prev_q <= active ? det_in : 1'b0;
  end

  assign evt = active && det_in && !det_prev_q;
`else
  assign evt = active && det_in;
`endif

  assign cnt_nxt  = (evt && (live_cnt_q != CNT_MAX)) ? live_cnt_q + 1'b1 : live_cnt_q;
  assign sat_nxt  = sat_q | (evt && (live_cnt_q == CNT_MAX));
  assign win_end  = active && (win_cnt_q == WIN_LAST);
  assign load     = win_end && (!snap_valid_q || snap.snap_ready);
  assign irq_fire = active && armed_q && (thresh != '0) && (cnt_nxt >= thresh);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      live_cnt_q <= '0;
      sat_q      <= 1'b0;
      win_cnt_q  <= '0;
      armed_q    <= 1'b1;
    end else if (!active || win_end) begin
      live_cnt_q <= '0;
      sat_q      <= 1'b0;
      win_cnt_q  <= '0;
      armed_q    <= 1'b1;
    end else begin
      live_cnt_q <= cnt_nxt;
      sat_q      <= sat_nxt;
      win_cnt_q  <= win_cnt_q + 1'b1;
      armed_q    <= armed_q & ~irq_fire;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      irq_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_count_q <= '0;
      snap_sat_q   <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      irq_q <= irq_fire;
      if (load) begin
        snap_valid_q <= 1'b1;
        snap_count_q <= cnt_nxt;
        snap_sat_q   <= sat_nxt;
      end else if (snap_valid_q && snap.snap_ready) begin
        snap_valid_q <= 1'b0;
      end
      // A dropped window end outranks a simultaneous clear.
      if (win_end && !load) ovr_q <= 1'b1;
      else if (clr_ovr)     ovr_q <= 1'b0;
    end
  end

  assign snap.snap_valid = snap_valid_q;
  assign snap.snap_count = snap_count_q;
  assign snap.snap_sat   = snap_sat_q;
  assign snap_ovr        = ovr_q;
  assign irq             = irq_q;
  assign busy            = (state_q == S_RUN);

endmodule

// File: tb/tb_detect_event_monitor.sv
// Scoreboard bench for detect_event_monitor with CNT_W=4, WINDOW=16.
module tb_detect_event_monitor;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 16;
  localparam int WINDOW = 16;

`ifdef DET_MON_EDGE_EN
  localparam logic [CNT_W-1:0] SAT_CNT = 4'd1;
  localparam logic             SAT_BIT = 1'b0;
`else
  localparam logic [CNT_W-1:0] SAT_CNT = 4'd15;
  localparam logic             SAT_BIT = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             arstn;
  logic             det_in;
  logic             en;
  logic [CNT_W-1:0] thresh;
  logic             clr_ovr;
  logic             snap_ovr;
  logic             irq;
  logic             busy;

  detect_event_monitor_if #(.CNT_W(CNT_W)) snap_if ();

  detect_event_monitor #(
    .CNT_W (CNT_W),
    .WIN_W (WIN_W),
    .WINDOW(WINDOW)
  ) dut (
    .clk     (clk),
    .arstn   (arstn),
    .det_in  (det_in),
    .en      (en),
    .thresh  (thresh),
    .clr_ovr (clr_ovr),
    .snap_ovr(snap_ovr),
    .irq     (irq),
    .busy    (busy),
    .snap    (snap_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] count;
    logic             sat;
  } snap_t;

  snap_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  int    irq_n  = 0;
  int    irq_at = -1;
  int    w0     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [CNT_W-1:0] c, input logic s);
    snap_t e;
    e.count = c;
    e.sat   = s;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic d, input logic r, input logic c);
    det_in             = d;
    snap_if.snap_ready = r;
    clr_ovr            = c;
    @(posedge clk);
    #1;
  endtask

  // Runs one full window; the next posedge must be window cycle 0.
  task automatic run_window(input logic [15:0] dp, input logic [15:0] rp, input logic [15:0] cp);
    w0 = cyc + 1;
    for (int i = 0; i < WINDOW; i++) step(dp[i], rp[i], cp[i]);
    det_in             = 1'b0;
    snap_ify_idle();
  endtask

  task automatic snap_ify_idle();
    snap_if.snap_ready = 1'b0;
    clr_ovr            = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: every accepted snapshot is compared with the oldest expectation.
  always @(negedge clk) begin : mon
    snap_t e;
    if (arstn === 1'b1) begin
      if (irq === 1'b1) begin
        irq_n++;
        irq_at = cyc;
      end
      if (snap_if.snap_valid && snap_if.snap_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_count", 32'(snap_if.snap_count), 32'(e.count));
          check("sb_sat", 32'(snap_if.snap_sat), 32'(e.sat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arstn              = 1'b0;
    en                 = 1'b0;
    det_in             = 1'b0;
    clr_ovr            = 1'b0;
    thresh             = '0;
    snap_if.snap_ready = 1'b0;
    #1;
    check("rst_valid", 32'(snap_if.snap_valid), 32'd0);
    check("rst_count", 32'(snap_if.snap_count), 32'd0);
    check("rst_sat",   32'(snap_if.snap_sat),   32'd0);
    check("rst_ovr",   32'(snap_ovr),           32'd0);
    check("rst_irq",   32'(irq),                32'd0);
    check("rst_busy",  32'(busy),               32'd0);
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    en    = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("busy_on", 32'(busy), 32'd1);

    // basic window: five isolated pulses, consumer not ready
    run_window(16'h0155, 16'h0000, 16'h0000);
    check("w1_valid", 32'(snap_if.snap_valid), 32'd1);
    check("w1_count", 32'(snap_if.snap_count), 32'd5);
    check("w1_sat",   32'(snap_if.snap_sat),   32'd0);
    check("w1_ovr",   32'(snap_ovr),           32'd0);
    push(4'd5, 1'b0);

    // second window dropped
    run_window(16'h0222, 16'h0000, 16'h0000);
    check("w2_count", 32'(snap_if.snap_count), 32'd5);
    check("w2_valid", 32'(snap_if.snap_valid), 32'd1);
    check("w2_ovr",   32'(snap_ovr),           32'd1);

    // clear overrun, then ready exactly on the window-end cycle
    run_window(16'h0049, 16'h8000, 16'h0001);
    check("w3_count", 32'(snap_if.snap_count), 32'd3);
    check("w3_valid", 32'(snap_if.snap_valid), 32'd1);
    check("w3_ovr",   32'(snap_ovr),           32'd0);
    push(4'd3, 1'b0);

    // saturation
    run_window(16'hFFFF, 16'h0001, 16'h0000);
    check("w4_count", 32'(snap_if.snap_count), 32'(SAT_CNT));
    check("w4_sat",   32'(snap_if.snap_sat),   32'(SAT_BIT));
    check("w4_noirq", 32'(irq_n),              32'd0);
    push(SAT_CNT, SAT_BIT);

    // threshold 3 reached at window cycle 9
    thresh = 4'd3;
    run_window(16'h0A24, 16'h0001, 16'h0000);
    check("w5_irq_n",  32'(irq_n),              32'd1);
    check("w5_irq_at", 32'(irq_at),             32'(w0 + 9));
    check("w5_count",  32'(snap_if.snap_count), 32'd4);
    push(4'd4, 1'b0);

    // threshold 0 disables irq
    thresh = '0;
    run_window(16'h0555, 16'h0001, 16'h0000);
    check("w6_irq_n", 32'(irq_n),              32'd1);
    check("w6_count", 32'(snap_if.snap_count), 32'd6);
    push(4'd6, 1'b0);

    // disable at window cycle 7 after four events
    for (int i = 0; i < 7; i++) step(((i % 2) == 0), (i == 0), 1'b0);
    check("w7_busy", 32'(busy), 32'd1);
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("dis_busy",  32'(busy),               32'd0);
    check("dis_valid", 32'(snap_if.snap_valid), 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("dis_valid2", 32'(snap_if.snap_valid), 32'd0);
    check("dis_ovr",    32'(snap_ovr),           32'd0);
    en = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("reen_busy", 32'(busy), 32'd1);
    run_window(16'h000A, 16'h0000, 16'h0000);
    check("w8_valid", 32'(snap_if.snap_valid), 32'd1);
    check("w8_count", 32'(snap_if.snap_count), 32'd2);
    push(4'd2, 1'b0);

    // asynchronous reset mid-window with the snapshot pending
    for (int i = 0; i < 5; i++) step((i == 1) || (i == 3), 1'b0, 1'b0);
    #2;
    arstn = 1'b0;
    #1;
    check("ar_valid", 32'(snap_if.snap_valid), 32'd0);
    check("ar_count", 32'(snap_if.snap_count), 32'd0);
    check("ar_sat",   32'(snap_if.snap_sat),   32'd0);
    check("ar_ovr",   32'(snap_ovr),           32'd0);
    check("ar_irq",   32'(irq),                32'd0);
    check("ar_busy",  32'(busy),               32'd0);
    exp_q.delete();
    #2;
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check("ar_run", 32'(busy), 32'd1);
    run_window(16'h1110, 16'h0000, 16'h0000);
    check("w10_valid", 32'(snap_if.snap_valid), 32'd1);
    check("w10_count", 32'(snap_if.snap_count), 32'd3);
    check("w10_sat",   32'(snap_if.snap_sat),   32'd0);
    check("w10_ovr",   32'(snap_ovr),           32'd0);
    push(4'd3, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("end_valid", 32'(snap_if.snap_valid), 32'd0);
    check("sb_drain",  32'(exp_q.size()),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/detect_event_monitor.md
# detect_event_monitor

Windowed event monitor that sits directly downstream of the serial sequence detector. It consumes the detector's one-bit match output, counts matches over fixed-length windows of enabled clock cycles, and hands each window's count to software/bus logic through a valid/ready snapshot port. It also raises a threshold interrupt and reports saturation and snapshot-overrun conditions.

## Interface
- `CNT_W`, 8: width of the live and snapshot match counters.
- `WIN_W`, 16: width of the window cycle counter.
- `WINDOW`, 1000: window length in enabled cycles; legal range 2 .. 2^WIN_W.

- `clk` in 1: single clock, all state on posedge.
- `arstn` in 1: asynchronous, active-low reset.
- `det_in` in 1: match output of the sequence detector, sampled every posedge.
- `en` in 1: monitor enable, level.
- `thresh` in CNT_W: interrupt threshold; 0 disables irq.
- `snap_ready` in 1: consumer accepts the snapshot.
- `clr_ovr` in 1: one-cycle pulse that clears `snap_ovr`.
- `snap_valid` out 1: snapshot held and valid.
- `snap_count` out CNT_W: matches counted in the completed window.
- `snap_sat` out 1: the live counter saturated during that window.
- `snap_ovr` out 1: sticky flag; a window end was dropped.
- `irq` out 1: one-cycle threshold pulse.
- `busy` out 1: FSM is in RUN.

## Operation
- FSM states:
  - IDLE: live count = 0, window counter = 0.
  - RUN: counting.
- Transitions:
  - IDLE→RUN on `en`=1.
  - RUN→IDLE on `en`=0. The partial window is discarded: no snapshot, live count and window counter cleared. Snapshot outputs are unaffected.
- Event qualification in RUN:
  - `det_in`=1 at a posedge counts one match.
  - Without the configured macro, every high cycle counts.
- Live counter: increments by 1 per qualified event and saturates at 2^CNT_W−1. A sat bit is set on any event arriving while the counter is saturated.
- Window counter: increments every RUN cycle from 0 up to WINDOW−1. Window end is the cycle where window count = WINDOW−1.
- At window end:
  - If `snap_valid`=0, or `snap_ready`=1 in the same cycle, load `snap_count`, `snap_sat` and set `snap_valid`=1. The loaded values are live count and sat bit including that cycle's event.
  - Otherwise the new value is dropped, the old snapshot is kept, and `snap_ovr` is set.
  - In both cases the live count, sat bit and window counter restart at 0.
- Snapshot handshake: transfer happens on posedge with `snap_valid`&&`snap_ready`. `snap_valid` drops the next cycle unless a window end reloads it in that same cycle.
- `snap_count` and `snap_sat` are stable while `snap_valid`=1.
- `irq`:
  - Pulses once per window, at the first cycle where the live count becomes ≥ `thresh`, with `thresh`≠0.
  - Re-armed at window end and on entry to IDLE.
  - If the threshold is reached on the window-end cycle, `irq` still fires.
- `snap_ovr`: cleared by `clr_ovr`. If set and clear hit the same cycle, set wins.

## Timing
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Reset mid-window or with a snapshot pending discards everything immediately (asynchronous).
- Event at posedge n is reflected in the internal count at n; `irq` is registered and visible in cycle n+1.
- Window end at posedge k: `snap_valid`/`snap_count` are visible in cycle k+1.
- `busy` goes high the cycle after `en` is first sampled high. The first RUN cycle is window cycle 0, and events in that cycle count.
- `det_in` is combinational from the detector. It must settle before the posedge and has no further registering.

## Configuration
- `DET_MON_EDGE_EN` defined:
  - Only 0→1 transitions of `det_in` count, so a high level held for N cycles counts once.
  - The previous-sample register resets to 0 and is cleared in IDLE, so a high `det_in` on the first RUN cycle counts.
- Undefined: level counting as described in Operation, with no previous-sample register.

## Test plan
All scenarios use CNT_W=4 and WINDOW=16 unless stated.
- **Basic window:** `en`=1; 5 single-cycle `det_in` pulses in the window; `snap_ready`=0 → `snap_valid`=1 at cycle 17 with `snap_count`=5, `snap_sat`=0.
- **Overrun:** as above, but hold `snap_ready`=0 through a second window with 3 pulses → `snap_count` stays 5 and `snap_ovr`=1. Pulse `clr_ovr` → `snap_ovr`=0. Same-cycle ready and window end → `snap_count` loads 3, `snap_ovr` stays 0.
- **Saturation:** `det_in` held high for all 16 cycles → `snap_count`=15, `snap_sat`=1. With `DET_MON_EDGE_EN` → `snap_count`=1, `snap_sat`=0.
- **Threshold:** `thresh`=3; pulses at window cycles 2, 5, 9, 11 → exactly one `irq`, in the cycle after window cycle 9. `thresh`=0 → no `irq`.
- **Disable mid-window:** deassert `en` at window cycle 7 after 4 events → no snapshot, `busy`=0. Re-enable → next snapshot counts only the new window.
- **Async reset mid-window:** `arstn`=0 with a snapshot pending → all outputs 0 immediately, and the next window starts clean.
